// File: rtl/floo_mcast_b_collector.sv
// Multicast B collector: tracks one outstanding multicast AW per ID, absorbs one B per destination,
// returns one merged B to the master. err_o/timeout_o are registered pulses (one cycle after the event).
// Optional collection timeout: define FLOO_MCAST_B_TIMEOUT_EN.
module floo_mcast_b_collector #(
  parameter int unsigned IdWidth       = 3,
  parameter int unsigned NumDst        = 4,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       aw_valid_i,
  output logic                       aw_ready_o,
  input  logic [IdWidth-1:0]         aw_id_i,
  input  logic [NumDst-1:0]          aw_mask_i,
  input  logic                       b_valid_i,
  output logic                       b_ready_o,
  input  logic [IdWidth-1:0]         b_id_i,
  input  logic [$clog2(NumDst)-1:0]  b_src_i,
  input  logic [1:0]                 b_resp_i,
  output logic                       b_valid_o,
  input  logic                       b_ready_i,
  output logic [IdWidth-1:0]         b_id_o,
  output logic [1:0]                 b_resp_o,
  output logic [2**IdWidth-1:0]      busy_o,
  output logic                       err_o,
  output logic                       timeout_o
);

  localparam int unsigned NumEntries = 2**IdWidth;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCollect = 2'd1;
  localparam logic [1:0] StDone    = 2'd2;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExOkay = 2'b01;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  // EXOKAY ranks below OKAY so it survives only if every destination returned it.
  function automatic logic [1:0] severity(input logic [1:0] resp);
    case (resp)
      RespExOkay: severity = 2'd0;
      RespOkay:   severity = 2'd1;
      RespSlvErr: severity = 2'd2;
      default:    severity = 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] merge_resp(input logic [1:0] acc, input logic [1:0] resp);
    merge_resp = (severity(resp) > severity(acc)) ? resp : acc;
  endfunction

  logic [1:0]          state_q   [NumEntries];
  logic [1:0]          state_d   [NumEntries];
  logic [NumDst-1:0]   pending_q [NumEntries];
  logic [NumDst-1:0]   pending_d [NumEntries];
  logic [1:0]          acc_q     [NumEntries];
  logic [1:0]          acc_d     [NumEntries];

  logic [IdWidth-1:0]  ptr_q, lock_id_q, grant, rr_idx, scan_idx;
  logic                lock_q, rr_found, out_hs, aw_fire;
  logic                b_hit, b_unexpected, src_in_range, err_q;
  logic [NumDst-1:0]   src_onehot, pending_left;
  logic [NumEntries-1:0] tmo_hit;

  assign aw_ready_o   = rst_ni & (state_q[aw_id_i] == StIdle);
  assign aw_fire      = aw_valid_i & aw_ready_o;
  assign b_ready_o    = rst_ni;
  assign src_in_range = 32'(b_src_i) < NumDst;

  always_comb begin
    for (int i = 0; i < NumEntries; i++) begin
      busy_o[i] = (state_q[i] != StIdle);
    end
  end

  // Round-robin scan over DONE entries starting at the pointer (one past the last grant).
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    scan_idx = '0;
    for (int k = 0; k < NumEntries; k++) begin
      scan_idx = ptr_q + IdWidth'(k);
      if (!rr_found && state_q[scan_idx] == StDone) begin
        rr_found = 1'b1;
        rr_idx   = scan_idx;
      end
    end
  end

  assign grant     = lock_q ? lock_id_q : rr_idx;
  assign b_valid_o = rst_ni & (lock_q | rr_found);
  assign out_hs    = b_valid_o & b_ready_i;
  assign b_id_o    = b_valid_o ? grant : '0;
  assign b_resp_o  = b_valid_o ? acc_q[grant] : RespOkay;

  // NOTE: every signal written here gets a default first, otherwise partial assignment infers a latch.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    acc_d        = acc_q;
    b_hit        = 1'b0;
    src_onehot   = '0;
    pending_left = '0;

    if (out_hs) state_d[grant] = StIdle;

    if (aw_fire) begin
      if (aw_mask_i != '0) begin
        state_d[aw_id_i]   = StCollect;
        pending_d[aw_id_i] = aw_mask_i;
        acc_d[aw_id_i]     = RespExOkay;
      end else begin
        state_d[aw_id_i] = StDone;
        acc_d[aw_id_i]   = RespOkay;
      end
    end

    // AW needs IDLE, B needs COLLECT, handshake needs DONE: the three never touch the same entry.
    if (b_valid_i && state_q[b_id_i] == StCollect && src_in_range && !tmo_hit[b_id_i]) begin
      src_onehot = NumDst'(1) << b_src_i;
      if ((pending_q[b_id_i] & src_onehot) != '0) begin
        b_hit              = 1'b1;
        pending_left       = pending_q[b_id_i] & ~src_onehot;
        pending_d[b_id_i]  = pending_left;
        acc_d[b_id_i]      = merge_resp(acc_q[b_id_i], b_resp_i);
        if (pending_left == '0) state_d[b_id_i] = StDone;
      end
    end

    for (int i = 0; i < NumEntries; i++) begin
      if (tmo_hit[i]) begin
        state_d[i]   = StDone;
        pending_d[i] = '0;
        acc_d[i]     = RespSlvErr;
      end
    end
  end

  assign b_unexpected = b_valid_i & b_ready_o & ~b_hit;

  // NOTE: the entry table is control state, so every entry is reset; none of it is plain data storage.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumEntries; i++) begin
        state_q[i]   <= StIdle;
        pending_q[i] <= '0;
        acc_q[i]     <= RespOkay;
      end
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the pre-edge values.
      for (int i = 0; i < NumEntries; i++) begin
        state_q[i]   <= state_d[i];
        pending_q[i] <= pending_d[i];
        acc_q[i]     <= acc_d[i];
      end
      if (out_hs) ptr_q <= grant + 1'b1;
      lock_q <= b_valid_o & ~b_ready_i;
      if (b_valid_o && !b_ready_i) lock_id_q <= grant;
      err_q <= b_unexpected;
    end
  end

  assign err_o = err_q;

`ifdef FLOO_MCAST_B_TIMEOUT_EN
  localparam int unsigned CntWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  logic [CntWidth-1:0] cnt_q [NumEntries];
  logic                tmo_q;

  always_comb begin
    for (int i = 0; i < NumEntries; i++) begin
      tmo_hit[i] = (state_q[i] == StCollect) && (cnt_q[i] == CntWidth'(TimeoutCycles - 1));
    end
  end

  // Counter idles at zero outside COLLECT, so it starts from zero on entry.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumEntries; i++) cnt_q[i] <= '0;
      tmo_q <= 1'b0;
    end else begin
      for (int i = 0; i < NumEntries; i++) begin
        cnt_q[i] <= (state_q[i] == StCollect) ? cnt_q[i] + CntWidth'(1) : '0;
      end
      tmo_q <= |tmo_hit;
    end
  end

  assign timeout_o = tmo_q;
`else
  assign tmo_hit   = '0;
  assign timeout_o = 1'b0;
`endif

endmodule
